// File: rtl/vga_sync_pkg.sv
// Shared definitions for the VGA sync timing decoder.
// Holds the lock FSM state type and the default counter widths.
package vga_sync_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_MEASURE,
        ST_LOCKED
    } state_t;

    localparam int H_W_DEF  = 11;
    localparam int V_W_DEF  = 10;
    localparam int LOCK_DEF = 2;

endpackage

// File: rtl/vga_sync_edge.sv
// Valid-gated falling-edge detector for an active-low sync line.
// Ports: clk_i, rst_ni, valid_i, sync_ni in; fall_o high in the falling sample.
module vga_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic valid_i,
    input  logic sync_ni,
    output logic fall_o
);

    logic r_prev;

    // Only valid samples update the history, so idle cycles never
    // create or hide an edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_prev <= 1'b1;
        end else if (valid_i) begin
            r_prev <= sync_ni;
        end
    end

    assign fall_o = valid_i & r_prev & ~sync_ni;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates and line/frame totals from a VGA sync stream.
// Ports: clk_i, rst_ni, valid_i, hsync_ni, vsync_ni, blank_ni in;
// x_o, y_o, pixel_o, h_total_o, v_total_o, locked_o, error_o out.
module vga_sync_decoder
    import vga_sync_pkg::*;
#(
    parameter int LOCK_FRAMES = LOCK_DEF,
    parameter int H_W         = H_W_DEF,
    parameter int V_W         = V_W_DEF
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           valid_i,
    input  logic           hsync_ni,
    input  logic           vsync_ni,
    input  logic           blank_ni,
    output logic [H_W-1:0] x_o,
    output logic [V_W-1:0] y_o,
    output logic           pixel_o,
    output logic [H_W-1:0] h_total_o,
    output logic [V_W-1:0] v_total_o,
    output logic           locked_o,
    output logic           error_o
);

    localparam int M_W = $clog2(LOCK_FRAMES + 1);
    localparam logic [M_W-1:0] LOCK_N = M_W'(LOCK_FRAMES);
    localparam logic [H_W-1:0] H_MAX  = '1;
    localparam logic [V_W-1:0] V_MAX  = '1;

    logic w_h_fall;
    logic w_v_fall;

    vga_sync_edge u_h_edge (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .sync_ni (hsync_ni),
        .fall_o  (w_h_fall)
    );

    vga_sync_edge u_v_edge (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .sync_ni (vsync_ni),
        .fall_o  (w_v_fall)
    );

    logic [H_W-1:0] r_h_cnt;
    logic [V_W-1:0] r_v_cnt;
    logic [H_W-1:0] r_x;
    logic [V_W-1:0] r_y;
    logic           r_line_vis;
    logic           r_line_seen;
    logic [H_W-1:0] r_line_len;

    state_t         r_state;
    logic [M_W-1:0] r_match;
    logic [H_W-1:0] r_prev_h;
    logic [V_W-1:0] r_prev_v;
    logic [H_W-1:0] r_h_total;
    logic [V_W-1:0] r_v_total;
    logic           r_locked;
    logic           r_err;
    logic [H_W-1:0] r_x_o;
    logic [V_W-1:0] r_y_o;
    logic           r_pix;

    logic [V_W-1:0] w_v_line;
    logic [H_W-1:0] w_x_cur;
    logic [V_W-1:0] w_y_cur;
    logic [H_W-1:0] w_frame_h;
    logic           w_h_bad;
    logic           w_same;
    logic [M_W-1:0] w_match_nx;
    logic           w_lk_bad;

    // Line end is applied before frame end, so a coincident hsync edge
    // still counts toward the frame that is closing.
    assign w_v_line = (w_h_fall && r_v_cnt != V_MAX) ?
                      r_v_cnt + V_W'(1) : r_v_cnt;

    assign w_x_cur = w_h_fall ? '0 : r_x;

    assign w_y_cur = w_v_fall ? '0 :
                     (w_h_fall && r_line_vis) ? r_y + V_W'(1) : r_y;

    // A coincident line end may be the first one of the frame.
    assign w_frame_h = (w_h_fall && !r_line_seen) ? r_h_cnt : r_line_len;

    assign w_h_bad = w_h_fall &&
                     (r_h_cnt == H_MAX ||
                      (r_line_seen && r_h_cnt != r_line_len));

    assign w_same = (r_match != '0) &&
                    (w_frame_h == r_prev_h) &&
                    (w_v_line == r_prev_v) &&
                    (w_v_line != V_MAX);

    assign w_match_nx = w_same ? r_match + M_W'(1) : M_W'(1);

    assign w_lk_bad = (w_h_fall &&
                       (r_h_cnt == H_MAX || r_h_cnt != r_h_total)) ||
                      (w_v_fall &&
                       (w_v_line == V_MAX || w_v_line != r_v_total));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_line_vis  <= 1'b0;
            r_line_seen <= 1'b0;
            r_line_len  <= '0;
            r_x_o       <= '0;
            r_y_o       <= '0;
            r_pix       <= 1'b0;
        end else begin
            r_pix <= 1'b0;
            if (valid_i) begin
                if (w_h_fall) begin
                    r_h_cnt <= H_W'(1);
                end else if (r_h_cnt != H_MAX) begin
                    r_h_cnt <= r_h_cnt + H_W'(1);
                end
                r_v_cnt <= w_v_fall ? '0 : w_v_line;
                if (w_h_fall && !r_line_seen) begin
                    r_line_len <= r_h_cnt;
                end
                r_line_seen <= w_v_fall ? 1'b0 :
                               (r_line_seen | w_h_fall);
                r_line_vis  <= (w_h_fall || w_v_fall) ? blank_ni :
                               (r_line_vis | blank_ni);
                r_x <= blank_ni ? w_x_cur + H_W'(1) : w_x_cur;
                r_y <= w_y_cur;
                r_pix <= blank_ni & r_locked;
                if (blank_ni) begin
                    r_x_o <= w_x_cur;
                    r_y_o <= w_y_cur;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_SEARCH;
            r_match   <= '0;
            r_prev_h  <= '0;
            r_prev_v  <= '0;
            r_h_total <= '0;
            r_v_total <= '0;
            r_locked  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (valid_i) begin
                unique case (r_state)
                    ST_SEARCH: begin
                        if (w_v_fall) begin
                            r_state <= ST_MEASURE;
                            r_match <= '0;
                        end
                    end
                    ST_MEASURE: begin
                        if (w_h_bad) begin
                            r_state <= ST_SEARCH;
                        end else if (w_v_fall) begin
                            r_prev_h <= w_frame_h;
                            r_prev_v <= w_v_line;
                            r_match  <= w_match_nx;
                            if (w_match_nx == LOCK_N) begin
                                r_state   <= ST_LOCKED;
                                r_locked  <= 1'b1;
                                r_h_total <= w_frame_h;
                                r_v_total <= w_v_line;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (w_lk_bad) begin
                            r_state  <= ST_SEARCH;
                            r_locked <= 1'b0;
                            r_err    <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_SEARCH;
                    end
                endcase
            end
        end
    end

    assign x_o       = r_x_o;
    assign y_o       = r_y_o;
    assign pixel_o   = r_pix;
    assign h_total_o = r_h_total;
    assign v_total_o = r_v_total;
    assign locked_o  = r_locked;
    assign error_o   = r_err;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for the VGA sync timing decoder.
// Drives synthetic frames and checks lock, totals and pixel coordinates.
module tb_vga_sync_decoder;

    logic        clk_i;
    logic        rst_ni;
    logic        valid_i;
    logic        hsync_ni;
    logic        vsync_ni;
    logic        blank_ni;
    logic [10:0] x_o;
    logic [9:0]  y_o;
    logic        pixel_o;
    logic [10:0] h_total_o;
    logic [9:0]  v_total_o;
    logic        locked_o;
    logic        error_o;

    vga_sync_decoder dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .valid_i   (valid_i),
        .hsync_ni  (hsync_ni),
        .vsync_ni  (vsync_ni),
        .blank_ni  (blank_ni),
        .x_o       (x_o),
        .y_o       (y_o),
        .pixel_o   (pixel_o),
        .h_total_o (h_total_o),
        .v_total_o (v_total_o),
        .locked_o  (locked_o),
        .error_o   (error_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_pass = 0;

    int g_ht, g_hv, g_vt, g_vv, g_vo, g_div;

    int m_pix, m_err, m_fx, m_fy, m_lx, m_ly;

    always @(negedge clk_i) begin
        if (pixel_o) begin
            if (m_pix == 0) begin
                m_fx = int'(x_o);
                m_fy = int'(y_o);
            end
            m_lx = int'(x_o);
            m_ly = int'(y_o);
            m_pix++;
        end
        if (error_o) m_err++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic mon_clear();
        m_pix = 0;
        m_err = 0;
        m_fx  = -1;
        m_fy  = -1;
        m_lx  = -1;
        m_ly  = -1;
    endtask

    task automatic drive(input logic h, input logic v, input logic b);
        for (int k = 1; k < g_div; k++) begin
            @(posedge clk_i);
            #1;
            valid_i  = 1'b0;
            hsync_ni = 1'b0;
            vsync_ni = 1'b0;
            blank_ni = 1'b1;
        end
        @(posedge clk_i);
        #1;
        valid_i  = 1'b1;
        hsync_ni = h;
        vsync_ni = v;
        blank_ni = b;
    endtask

    // hsync low for samples 0..2, visible from sample 4;
    // vsync low for lines 0..1 starting at sample g_vo, visible from line 3.
    task automatic send_lines(input int l0, input int l1, input int short_ln);
        for (int l = l0; l < l1; l++) begin
            int len;
            len = (l == short_ln) ? g_ht - 1 : g_ht;
            for (int s = 0; s < len; s++) begin
                logic h, v, b;
                h = (s >= 3);
                v = !(((l < 2) && !(l == 0 && s < g_vo)) ||
                      (l == 2 && s < g_vo));
                b = (l >= 3 && l < 3 + g_vv && s >= 4 && s < 4 + g_hv);
                drive(h, v, b);
            end
        end
    endtask

    task automatic send_frame(input int short_ln);
        send_lines(0, g_vt, short_ln);
    endtask

    task automatic settle();
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        valid_i = 1'b0;
        rst_ni  = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        #1;
    endtask

    initial begin
        rst_ni   = 1'b0;
        valid_i  = 1'b0;
        hsync_ni = 1'b1;
        vsync_ni = 1'b1;
        blank_ni = 1'b0;
        g_ht = 24; g_hv = 16; g_vt = 12; g_vv = 8; g_vo = 0; g_div = 1;
        mon_clear();
        do_reset();

        chk("rst_x", int'(x_o), 0);
        chk("rst_y", int'(y_o), 0);
        chk("rst_pix", int'(pixel_o), 0);
        chk("rst_htot", int'(h_total_o), 0);
        chk("rst_vtot", int'(v_total_o), 0);
        chk("rst_lock", int'(locked_o), 0);
        chk("rst_err", int'(error_o), 0);

        send_frame(-1);
        mon_clear();
        send_frame(-1);
        settle();
        chk("unlocked_pix", m_pix, 0);
        chk("lock_early", int'(locked_o), 0);

        mon_clear();
        send_frame(-1);
        settle();
        chk("lock", int'(locked_o), 1);
        chk("htot", int'(h_total_o), 24);
        chk("vtot", int'(v_total_o), 12);
        chk("pix_cnt", m_pix, 128);
        chk("first_x", m_fx, 0);
        chk("first_y", m_fy, 0);
        chk("last_x", m_lx, 15);
        chk("last_y", m_ly, 7);

        mon_clear();
        send_frame(5);
        settle();
        chk("err_pulses", m_err, 1);
        chk("short_lock", int'(locked_o), 0);
        chk("hold_htot", int'(h_total_o), 24);
        chk("hold_vtot", int'(v_total_o), 12);
        send_frame(-1);
        send_frame(-1);
        settle();
        chk("relock_early", int'(locked_o), 0);
        send_frame(-1);
        settle();
        chk("relock", int'(locked_o), 1);

        send_lines(0, 6, -1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_lock", int'(locked_o), 0);
        chk("mid_rst_htot", int'(h_total_o), 0);
        chk("mid_rst_vtot", int'(v_total_o), 0);
        chk("mid_rst_x", int'(x_o), 0);
        chk("mid_rst_y", int'(y_o), 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        send_lines(6, 12, -1);
        send_frame(-1);
        send_frame(-1);
        settle();
        chk("rst_relock_early", int'(locked_o), 0);
        send_frame(-1);
        settle();
        chk("rst_relock", int'(locked_o), 1);
        chk("rst_relock_vtot", int'(v_total_o), 12);

        do_reset();
        g_div = 4;
        send_frame(-1);
        send_frame(-1);
        mon_clear();
        send_frame(-1);
        settle();
        chk("div4_lock", int'(locked_o), 1);
        chk("div4_pix", m_pix, 128);
        chk("div4_first_x", m_fx, 0);
        chk("div4_first_y", m_fy, 0);
        chk("div4_last_x", m_lx, 15);
        chk("div4_last_y", m_ly, 7);
        g_div = 1;

        do_reset();
        g_ht = 800; g_hv = 640; g_vt = 8; g_vv = 4; g_vo = 100;
        send_frame(-1);
        send_frame(-1);
        mon_clear();
        send_frame(-1);
        settle();
        chk("wide_lock", int'(locked_o), 1);
        chk("wide_htot", int'(h_total_o), 800);
        chk("wide_vtot", int'(v_total_o), 8);
        chk("wide_pix", m_pix, 2560);
        chk("wide_first_x", m_fx, 0);
        chk("wide_last_x", m_lx, 639);
        chk("wide_last_y", m_ly, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
